keypad_scanner: RTL and testbench

- Upstream/downstream companion of the per-column edge debouncer in the elevator call-panel path.
- Strobes the 4 keypad columns one at a time and gates the debouncer enable for each column visit.
- Collects the debouncer's rising-edge row pulses, suppresses held keys across scan frames and encodes new presses into a 4-bit key code.
- Delivers key codes through a valid/ready handshake to the floor-request logic.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_scanner_if.sv | 13 +
 rtl/keypad_key_encoder.sv | 28 ++
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner slice: scan FSM states,
// matrix dimensions, key code type and a lowest-set-row priority helper.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        ADVANCE
    } scan_state_t;

    typedef logic [3:0] key_code_t;

    function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] bits);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (bits[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key code delivery handshake between the scanner (master) and the
// floor-request logic (slave).
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic      key_valid;
    logic      key_ready;
    key_code_t key_code;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/keypad_key_encoder.sv
// Combinational press detector for one column visit: picks the lowest newly
// pressed row, encodes it and returns the updated held-key slice.
module keypad_key_encoder
    import keypad_pkg::*;
(
    input  logic [NUM_ROWS-1:0] visit_mask,
    input  logic [NUM_ROWS-1:0] row_state,
    input  logic [1:0]          col,
    output logic                cand_valid,
    output key_code_t           cand_code,
    output logic [NUM_ROWS-1:0] row_next
);

    logic [NUM_ROWS-1:0] fresh;
    logic [1:0]          row;

    always_comb begin
        fresh      = visit_mask & ~row_state;
        row        = lowest_row(fresh);
        cand_valid = |fresh;
        cand_code  = {col, row};
        // Only the reported row is marked held; other fresh rows stay clear
        // so they come out one per later visit.
        row_next   = visit_mask & row_state;
        if (cand_valid) row_next[row] = 1'b1;
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing keypad scanner with held-key suppression and a one-entry
// key code buffer. Build macro KEYPAD_AUTOREPEAT_EN adds held-key auto-repeat.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DWELL_CYCLES  = 8,
    parameter int REPEAT_FRAMES = 32
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scan_en,
    input  logic [NUM_ROWS-1:0] button_edge,
    output logic [NUM_COLS-1:0] col_drive,
    output logic                deb_en,
    keypad_scanner_if.master    key_out,
    output logic                overrun
);

    // state   | meaning
    // IDLE    | scanning parked, strobes and debouncer off
    // DRIVE   | strobe column, debouncer held in flush
    // SAMPLE  | debouncer enabled, collect row edges for DWELL_CYCLES
    // ADVANCE | encode the visit, push key code, step to next column

    localparam int DW_W = $clog2(DWELL_CYCLES);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

    if (DWELL_CYCLES < 4 || REPEAT_FRAMES < 1) begin : g_bad_param
        $error("keypad_scanner: DWELL_CYCLES must be >= 4 and REPEAT_FRAMES >= 1");
    end

    scan_state_t         state;
    logic [1:0]          col;
    logic [1:0]          col_next;
    logic [DW_W-1:0]     dwell;
    logic [NUM_ROWS-1:0] visit_mask;
    logic [15:0]         down_map;
    logic [NUM_ROWS-1:0] row_state;
    logic [NUM_ROWS-1:0] row_next;
    logic                cand_valid;
    key_code_t           cand_code;
    logic                push_valid;
    key_code_t           push_code;
    logic                key_valid;
    key_code_t           key_code;

    assign key_out.key_valid = key_valid;
    assign key_out.key_code  = key_code;
    assign col_next          = col + 2'd1;
    assign row_state         = down_map[{col, 2'b00} +: NUM_ROWS];

    keypad_key_encoder u_encoder (
        .visit_mask (visit_mask),
        .row_state  (row_state),
        .col        (col),
        .cand_valid (cand_valid),
        .cand_code  (cand_code),
        .row_next   (row_next)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_FRAMES > 32) ? $clog2(REPEAT_FRAMES) : 5;
    localparam logic [RPT_W-1:0] RPT_LOAD = RPT_W'(REPEAT_FRAMES - 1);

    logic             rpt_active;
    key_code_t        rpt_key;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_visit;
    logic             rpt_held;
    logic             rpt_fire;

    assign rpt_visit = rpt_active && (rpt_key[3:2] == col);
    assign rpt_held  = visit_mask[rpt_key[1:0]];
    // A genuinely new press in the same visit wins; the repeat retries next frame.
    assign rpt_fire  = rpt_visit && rpt_held && (rpt_cnt == '0) && !cand_valid;
`endif

    always_comb begin
        push_valid = cand_valid;
        push_code  = cand_code;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (rpt_fire) begin
            push_valid = 1'b1;
            push_code  = rpt_key;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            dwell      <= '0;
            visit_mask <= '0;
            down_map   <= '0;
            col_drive  <= '0;
            deb_en     <= 1'b0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            overrun    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_active <= 1'b0;
            rpt_key    <= '0;
            rpt_cnt    <= '0;
`endif
        end else begin
            if (key_valid && key_out.key_ready) key_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    // col is kept across IDLE so a re-enable resumes the frame.
                    if (scan_en) begin
                        state     <= DRIVE;
                        col_drive <= 4'b0001 << col;
                    end
                end
                DRIVE: begin
                    state      <= SAMPLE;
                    deb_en     <= 1'b1;
                    dwell      <= DWELL_LAST;
                    visit_mask <= '0;
                end
                SAMPLE: begin
                    visit_mask <= visit_mask | button_edge;
                    if (dwell == '0) begin
                        state  <= ADVANCE;
                        deb_en <= 1'b0;
                    end else begin
                        dwell <= dwell - 1'b1;
                    end
                end
                ADVANCE: begin
                    down_map[{col, 2'b00} +: NUM_ROWS] <= row_next;
                    if (push_valid) begin
                        if (!key_valid || key_out.key_ready) begin
                            key_valid <= 1'b1;
                            key_code  <= push_code;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rpt_visit) begin
                        if (!rpt_held)            rpt_active <= 1'b0;
                        else if (rpt_fire)        rpt_cnt    <= RPT_LOAD;
                        else if (rpt_cnt != '0)   rpt_cnt    <= rpt_cnt - 1'b1;
                    end else if (!rpt_active && cand_valid) begin
                        rpt_active <= 1'b1;
                        rpt_key    <= cand_code;
                        rpt_cnt    <= RPT_LOAD;
                    end
`endif
                    col <= col_next;
                    if (scan_en) begin
                        state     <= DRIVE;
                        col_drive <= 4'b0001 << col_next;
                    end else begin
                        state     <= IDLE;
                        col_drive <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: scan timing, press encoding, held-key
// suppression, overrun, scan_en parking and async reset.
module tb_keypad_scanner;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT = 2;
`else
    localparam int RPT = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_en = 1'b0;
    logic [3:0]  button_edge = '0;
    logic [3:0]  col_drive;
    logic        deb_en;
    logic        overrun;
    logic [15:0] pressed = '0;
    logic [3:0]  got[$];
    int          total = 0;
    int          bad = 0;

    keypad_scanner_if key_out();

    keypad_scanner #(.DWELL_CYCLES(8), .REPEAT_FRAMES(RPT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .button_edge (button_edge),
        .col_drive   (col_drive),
        .deb_en      (deb_en),
        .key_out     (key_out),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] rows_for(input logic [3:0] strobe, input logic [15:0] keys);
        case (strobe)
            4'b0001: return keys[3:0];
            4'b0010: return keys[7:4];
            4'b0100: return keys[11:8];
            4'b1000: return keys[15:12];
            default: return 4'b0000;
        endcase
    endfunction

    // Debouncer stand-in and consumer monitor, both sampling mid-cycle.
    initial forever begin
        @(negedge clk);
        #1;
        if (key_out.key_valid && key_out.key_ready) got.push_back(key_out.key_code);
        button_edge = deb_en ? rows_for(col_drive, pressed) : 4'b0000;
    end

    initial begin
        int  k;
        logic found;
        key_out.key_ready = 1'b1;
        scan_en = 1'b1;
        cycles(3);
        check_val("rst_col_drive", col_drive, 4'b0000);
        check_val("rst_deb_en", deb_en, 1'b0);
        check_val("rst_key_valid", key_out.key_valid, 1'b0);
        check_val("rst_key_code", key_out.key_code, 4'b0000);
        check_val("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;

        // Scan timing: DRIVE, 8 x SAMPLE, ADVANCE for each column in turn.
        k = 0;
        while (col_drive == 4'b0000 && k < 10) begin
            cycles(1);
            k++;
        end
        check_val("t1_start", col_drive, 4'b0001);
        for (int i = 0; i < 40; i++) begin
            check_val($sformatf("t1_scan_%0d", i), {col_drive, deb_en},
                      {4'b0001 << (i / 10), ((i % 10) >= 1 && (i % 10) <= 8)});
            cycles(1);
        end

`ifndef KEYPAD_AUTOREPEAT_EN
        // Held key col2,row1 emits once; release and re-press emits again.
        got.delete();
        pressed[9] = 1'b1;
        cycles(120);
        check_val("t2_count", got.size(), 1);
        check_val("t2_code", (got.size() > 0) ? got[0] : 4'hx, 4'b1001);
        pressed = '0;
        cycles(80);
        check_val("t2_release_count", got.size(), 1);
        pressed[9] = 1'b1;
        cycles(80);
        check_val("t2_repress_count", got.size(), 2);
        check_val("t2_repress_code", (got.size() > 1) ? got[1] : 4'hx, 4'b1001);
        pressed = '0;
        cycles(80);

        // Two rows in col0: lowest first, the other next frame, then quiet.
        got.delete();
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        cycles(160);
        check_val("t3_count", got.size(), 2);
        check_val("t3_first", (got.size() > 0) ? got[0] : 4'hx, 4'b0000);
        check_val("t3_second", (got.size() > 1) ? got[1] : 4'hx, 4'b0011);
        pressed = '0;
        cycles(80);

        // Full buffer: second press dropped, overrun sticks after pop.
        check_val("t4_overrun_pre", overrun, 1'b0);
        got.delete();
        key_out.key_ready = 1'b0;
        pressed[4] = 1'b1;
        cycles(44);
        pressed[14] = 1'b1;
        cycles(44);
        check_val("t4_valid_held", key_out.key_valid, 1'b1);
        check_val("t4_code_held", key_out.key_code, 4'b0100);
        check_val("t4_overrun", overrun, 1'b1);
        key_out.key_ready = 1'b1;
        cycles(3);
        check_val("t4_pop_count", got.size(), 1);
        check_val("t4_pop_code", (got.size() > 0) ? got[0] : 4'hx, 4'b0100);
        check_val("t4_valid_after", key_out.key_valid, 1'b0);
        check_val("t4_overrun_after", overrun, 1'b1);
        pressed = '0;
        cycles(80);
`else
        // Auto-repeat: held col3,row3 re-emits every 2 frames.
        got.delete();
        pressed[15] = 1'b1;
        k = 0;
        while (got.size() == 0 && k < 90) begin
            cycles(1);
            k++;
        end
        check_val("ar_first", got.size(), 1);
        cycles(170);
        check_val("ar_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            check_val($sformatf("ar_code_%0d", i), (got.size() > i) ? got[i] : 4'hx, 4'b1111);
        pressed = '0;
        cycles(80);
`endif

        // scan_en dropped during col1 SAMPLE: visit completes, then IDLE.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (col_drive == 4'b0010 && deb_en) found = 1'b1;
            else cycles(1);
        end
        check_val("t5_found", found, 1'b1);
        scan_en = 1'b0;
        cycles(1);
        check_val("t5_still_col1", col_drive, 4'b0010);
        cycles(12);
        check_val("t5_idle_col", col_drive, 4'b0000);
        check_val("t5_idle_deb", deb_en, 1'b0);
        scan_en = 1'b1;
        k = 0;
        while (col_drive == 4'b0000 && k < 5) begin
            cycles(1);
            k++;
        end
        check_val("t5_resume_col", col_drive, 4'b0100);
        check_val("t5_resume_deb", deb_en, 1'b0);

        // Asynchronous reset mid-SAMPLE clears outputs without a clock edge.
        k = 0;
        while (!deb_en && k < 20) begin
            cycles(1);
            k++;
        end
        check_val("t6_in_sample", deb_en, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check_val("t6_col_drive", col_drive, 4'b0000);
        check_val("t6_deb_en", deb_en, 1'b0);
        check_val("t6_key_valid", key_out.key_valid, 1'b0);
        check_val("t6_key_code", key_out.key_code, 4'b0000);
        check_val("t6_overrun", overrun, 1'b0);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
